gaussian_frame_ctrl: RTL and testbench

Frame sequencer for the 5x5 Gaussian operator. It walks the padded scan of (IMG_WIDTH+4) x (IMG_HEIGHT+4) window positions, which pulls source pixels and inserts flush positions. It drives the window shift enable and the `x`/`y` coordinates into the window buffer and operator, and tracks each result through the operator's fixed latency. Results land in a small credit-protected FIFO, so downstream backpressure never corrupts the unbuffered operator output.

---
 rtl/gaussian_pkg.sv | 29 ++
 rtl/result_fifo.sv | 67 ++++++
 rtl/gaussian_frame_ctrl.sv | 178 +++++++++++++++++
 tb/tb_gaussian_frame_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gaussian_pkg.sv
// gaussian_pkg
// Shared definitions for the 5x5 Gaussian frame sequencer:
//   CLOG2      - constant ceil(log2(n)) used to size counters and ports
//   KERNEL     - window edge length
//   PAD        - extra scan positions per line/frame that flush the window
//   CENTER_OFF - offset from the scan position to the window centre
//   state_t    - sequencer states
package gaussian_pkg;

    function automatic int CLOG2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    localparam int KERNEL     = 5;
    localparam int PAD        = KERNEL - 1;
    localparam int CENTER_OFF = KERNEL / 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/result_fifo.sv
// result_fifo
// Small synchronous FIFO holding operator results until downstream pops them.
// A push and a pop in the same cycle both take effect, also when full.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset (empties the FIFO)
//   push, din     - write request and data
//   pop           - read request; ignored when empty
//   dout          - head entry (undefined when empty)
//   count         - number of stored entries
//   full, empty   - status flags
module result_fifo
    import gaussian_pkg::*;
#(
    parameter  int DEPTH  = 4,
    parameter  int DWIDTH = 8,
    localparam int CW     = CLOG2(DEPTH + 1),
    localparam int AW     = (CLOG2(DEPTH) > 0) ? CLOG2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DWIDTH-1:0] din,
    output logic [DWIDTH-1:0] dout,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty
);

    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic              w_do_push;
    logic              w_do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty     = (r_count == '0);
    assign full      = (r_count == CW'(DEPTH));
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign count     = r_count;
    assign dout      = r_mem[r_rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= ptr_inc(r_wptr);
            if (w_do_pop)  r_rptr <= ptr_inc(r_rptr);
            if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
            else if (!w_do_push && w_do_pop) r_count <= r_count - CW'(1);
        end
    end

    // Storage carries no reset; only entries below count are ever observed.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= din;
    end

endmodule

// File: rtl/gaussian_frame_ctrl.sv
// gaussian_frame_ctrl
// Walks the padded (IMG_WIDTH+4) x (IMG_HEIGHT+4) window scan for the 5x5
// Gaussian operator, pulling source pixels at active positions and inserting
// flush positions elsewhere. Each productive position is tracked through the
// operator latency and its result is captured in a credit-protected FIFO.
// Ports:
//   clock, reset  - clock, asynchronous active-low reset
//   start         - frame start pulse, honoured only when idle
//   in_valid      - source pixel valid; in_ready - pixel accepted (with in_valid)
//   shift_en      - advance window/line buffers one position
//   x, y          - scan coordinate of the window currently held
//   op_out        - operator result, OP_LATENCY cycles after x/y
//   out_data/out_valid/out_ready - result FIFO head handshake
//   busy          - sequencer not idle
//   frame_done    - one-cycle pulse once the last result has left the FIFO
module gaussian_frame_ctrl
    import gaussian_pkg::*;
#(
    parameter  int IMG_WIDTH  = 720,
    parameter  int IMG_HEIGHT = 540,
    parameter  int DWIDTH     = 8,
    parameter  int OP_LATENCY = 1,
    parameter  int FIFO_DEPTH = 4,
    localparam int XW         = CLOG2(IMG_WIDTH + 5),
    localparam int YW         = CLOG2(IMG_HEIGHT + 5)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              shift_en,
    output logic [XW-1:0]     x,
    output logic [YW-1:0]     y,
    input  logic [DWIDTH-1:0] op_out,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              frame_done
);

    localparam int CW = CLOG2(FIFO_DEPTH + 1);

    localparam logic [XW-1:0] X_LAST  = XW'(IMG_WIDTH + PAD - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(IMG_HEIGHT + PAD - 1);
    localparam logic [XW-1:0] X_ACT   = XW'(IMG_WIDTH);
    localparam logic [YW-1:0] Y_ACT   = YW'(IMG_HEIGHT);
    localparam logic [XW-1:0] X_P_LO  = XW'(CENTER_OFF);
    localparam logic [YW-1:0] Y_P_LO  = YW'(CENTER_OFF);
    localparam logic [XW-1:0] X_P_HI  = XW'(IMG_WIDTH + CENTER_OFF - 1);
    localparam logic [YW-1:0] Y_P_HI  = YW'(IMG_HEIGHT + CENTER_OFF - 1);
    localparam logic [CW:0]   CREDITS = (CW + 1)'(FIFO_DEPTH);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [XW-1:0]       r_px;
    logic [YW-1:0]       r_py;
    logic [XW-1:0]       r_x;
    logic [YW-1:0]       r_y;
    logic [OP_LATENCY:0] r_vpipe;

    logic                w_need_in;
    logic                w_prod;
    logic                w_last_pos;
    logic [CW:0]         w_inflight;
    logic                w_credit_ok;
    logic                w_shift_en;
    logic                w_in_ready;
    logic                w_frame_done;
    logic [CW-1:0]       w_fifo_count;
    logic                w_fifo_full;
    logic                w_fifo_empty;

    assign w_need_in  = (r_px < X_ACT) && (r_py < Y_ACT);
    assign w_prod     = (r_px >= X_P_LO) && (r_px <= X_P_HI) &&
                        (r_py >= Y_P_LO) && (r_py <= Y_P_HI);
    assign w_last_pos = (r_px == X_LAST) && (r_py == Y_LAST);

    // Results already in the pipe hold a FIFO slot, so the pipe never has to
    // stall and the unbuffered operator output is always captured.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i <= OP_LATENCY; i++) begin
            w_inflight = w_inflight + (CW + 1)'(r_vpipe[i]);
        end
    end

    // The full check is implied by the credit sum; it is kept as a cheap guard.
    assign w_credit_ok = ((w_inflight + (CW + 1)'(w_fifo_count)) < CREDITS) && !w_fifo_full;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_shift_en   = 1'b0;
        w_in_ready   = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = RUN;
            end
            RUN: begin
                w_in_ready = w_credit_ok && w_need_in;
                w_shift_en = w_credit_ok && (!w_need_in || in_valid);
                if (w_shift_en && w_last_pos) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if ((r_vpipe == '0) && w_fifo_empty) begin
                    w_frame_done = 1'b1;
                    w_state_nxt  = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Scan position and the coordinate of the window now held downstream.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_px <= '0;
            r_py <= '0;
            r_x  <= '0;
            r_y  <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_px <= '0;
            r_py <= '0;
        end else if (w_shift_en) begin
            r_x <= r_px;
            r_y <= r_py;
            if (r_px == X_LAST) begin
                r_px <= '0;
                r_py <= (r_py == Y_LAST) ? '0 : r_py + YW'(1);
            end else begin
                r_px <= r_px + XW'(1);
            end
        end
    end

    // Stage 0 marks a productive shift; the last stage coincides with op_out.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_vpipe <= '0;
        end else begin
            r_vpipe[0] <= w_shift_en && w_prod;
            for (int i = 1; i <= OP_LATENCY; i++) begin
                r_vpipe[i] <= r_vpipe[i-1];
            end
        end
    end

    result_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DWIDTH (DWIDTH)
    ) u_result_fifo (
        .clk   (clock),
        .rst_n (reset),
        .push  (r_vpipe[OP_LATENCY]),
        .pop   (out_ready),
        .din   (op_out),
        .dout  (out_data),
        .count (w_fifo_count),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    assign in_ready   = w_in_ready;
    assign shift_en   = w_shift_en;
    assign x          = r_x;
    assign y          = r_y;
    assign out_valid  = !w_fifo_empty;
    assign busy       = (r_state != IDLE);
    assign frame_done = w_frame_done;

endmodule

// File: tb/tb_gaussian_frame_ctrl.sv
module tb_gaussian_frame_ctrl;

    localparam int W    = 4;
    localparam int H    = 3;
    localparam int SW   = W + 4;
    localparam int NPOS = (W + 4) * (H + 4);
    localparam int NRES = W * H;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready, shift_en, out_valid, busy, frame_done;
    logic [3:0] x;
    logic [2:0] y;
    logic [7:0] op_out = 8'h00;
    logic [7:0] out_data;

    int tests_run = 0;
    int fail_cnt  = 0;

    int cyc = 0;
    int s_pre = 0;
    int shift_cnt, acc_cnt, done_cnt, prod_cnt, first_ov;
    int shift_cyc [NPOS];
    logic [7:0] got_q [$];

    gaussian_frame_ctrl #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .DWIDTH    (8),
        .OP_LATENCY(1),
        .FIFO_DEPTH(4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .shift_en  (shift_en),
        .x         (x),
        .y         (y),
        .op_out    (op_out),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    // Operator stand-in: a coordinate hash behind one output register.
    function automatic logic [7:0] op_hash(input int xx, input int yy);
        return 8'((xx * 37 + yy * 11 + 5) % 256);
    endfunction

    always @(posedge clock) op_out <= op_hash(int'(x), int'(y));

    // Reference model of the scan in terms of position index.
    function automatic bit pos_need_in(input int idx);
        return ((idx % SW) < W) && ((idx / SW) < H);
    endfunction

    function automatic bit pos_prod(input int idx);
        int px, py;
        px = idx % SW;
        py = idx / SW;
        return (px >= 2) && (px <= W + 1) && (py >= 2) && (py <= H + 1);
    endfunction

    // k-th result in raster order is the window centred on pixel (k%W, k/W).
    function automatic logic [7:0] exp_result(input int k);
        return op_hash(k % W + 2, k / W + 2);
    endfunction

    task automatic clear_counts();
        shift_cnt = 0;
        acc_cnt   = 0;
        done_cnt  = 0;
        prod_cnt  = 0;
        first_ov  = -1;
        got_q.delete();
    endtask

    // One clock cycle: drive inputs after the edge, observe at the falling edge.
    task automatic tick(input logic st, input logic iv, input logic ordy);
        @(posedge clock);
        #1;
        start     = st;
        in_valid  = iv;
        out_ready = ordy;
        @(negedge clock);
        cyc++;
        s_pre = shift_cnt;
        if (shift_en === 1'b1) begin
            if (shift_cnt < NPOS) shift_cyc[shift_cnt] = cyc;
            if (in_ready === 1'b1) acc_cnt++;
            if (pos_prod(shift_cnt)) prod_cnt++;
            shift_cnt++;
        end
        if (out_valid === 1'b1 && first_ov < 0) first_ov = cyc;
        if (out_valid === 1'b1 && out_ready === 1'b1) got_q.push_back(out_data);
        if (frame_done === 1'b1) done_cnt++;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        repeat (2) @(negedge clock);
        tests_run++; if (in_ready !== 1'b0)   begin fail_cnt++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        tests_run++; if (shift_en !== 1'b0)   begin fail_cnt++; $display("FAIL reset_shift_en got %b want 0", shift_en); end
        tests_run++; if (out_valid !== 1'b0)  begin fail_cnt++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests_run++; if (busy !== 1'b0)       begin fail_cnt++; $display("FAIL reset_busy got %b want 0", busy); end
        tests_run++; if (frame_done !== 1'b0) begin fail_cnt++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
        tests_run++; if (x !== 4'd0 || y !== 3'd0) begin fail_cnt++; $display("FAIL reset_xy got %0d,%0d want 0,0", x, y); end
        @(posedge clock);
        #1 reset = 1'b1;
    endtask

    task automatic test_free_run();
        int c0;
        clear_counts();
        tick(1'b1, 1'b1, 1'b1);
        c0 = cyc;
        for (int n = 0; n < 200 && done_cnt == 0; n++) tick(1'b0, 1'b1, 1'b1);
        tests_run++; if (shift_cnt != NPOS) begin fail_cnt++; $display("FAIL free_shift_count got %0d want %0d", shift_cnt, NPOS); end
        tests_run++;
        if (shift_cnt != NPOS || shift_cyc[0] != c0 + 1 || shift_cyc[NPOS-1] - shift_cyc[0] != NPOS - 1) begin
            fail_cnt++; $display("FAIL free_consecutive got first=%0d span=%0d want first=%0d span=%0d",
                                 shift_cyc[0] - c0, shift_cyc[NPOS-1] - shift_cyc[0], 1, NPOS - 1);
        end
        tests_run++; if (acc_cnt != NRES) begin fail_cnt++; $display("FAIL free_accepts got %0d want %0d", acc_cnt, NRES); end
        tests_run++; if (first_ov - shift_cyc[2*SW+2] != 3) begin fail_cnt++; $display("FAIL free_latency got %0d want 3", first_ov - shift_cyc[2*SW+2]); end
        tests_run++; if (got_q.size() != NRES) begin fail_cnt++; $display("FAIL free_result_count got %0d want %0d", got_q.size(), NRES); end
        for (int k = 0; k < got_q.size() && k < NRES; k++) begin
            tests_run++; if (got_q[k] !== exp_result(k)) begin fail_cnt++; $display("FAIL free_result[%0d] got %h want %h", k, got_q[k], exp_result(k)); end
        end
        tests_run++; if (done_cnt != 1) begin fail_cnt++; $display("FAIL free_done got %0d want 1", done_cnt); end
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        tests_run++; if (busy !== 1'b0 || done_cnt != 1) begin fail_cnt++; $display("FAIL free_idle_after busy=%b done=%0d want 0,1", busy, done_cnt); end
    endtask

    task automatic test_wrap();
        clear_counts();
        tick(1'b1, 1'b1, 1'b1);
        for (int n = 0; n < 400 && done_cnt == 0; n++) begin
            tick(1'b0, 1'($urandom_range(0, 1)), 1'b1);
            if (s_pre > 0) begin
                tests_run++;
                if (x !== 4'((s_pre - 1) % SW) || y !== 3'((s_pre - 1) / SW)) begin
                    fail_cnt++; $display("FAIL wrap_xy pos %0d got %0d,%0d want %0d,%0d", s_pre - 1, x, y, (s_pre - 1) % SW, (s_pre - 1) / SW);
                end
            end
        end
        tests_run++; if (x !== 4'd7 || y !== 3'd6) begin fail_cnt++; $display("FAIL wrap_final got %0d,%0d want 7,6", x, y); end
        tests_run++; if (done_cnt != 1) begin fail_cnt++; $display("FAIL wrap_done got %0d want 1", done_cnt); end
    endtask

    task automatic test_starvation();
        logic iv;
        int   flush_dry;
        logic exp_sh;
        flush_dry = 0;
        clear_counts();
        tick(1'b1, 1'b0, 1'b1);
        for (int n = 0; n < 400 && done_cnt == 0; n++) begin
            iv = 1'(n % 2);
            tick(1'b0, iv, 1'b1);
            if (s_pre < NPOS) begin
                exp_sh = pos_need_in(s_pre) ? iv : 1'b1;
                if (!pos_need_in(s_pre) && !iv && shift_en === 1'b1) flush_dry++;
                tests_run++;
                if (shift_en !== exp_sh) begin
                    fail_cnt++; $display("FAIL starve_shift pos %0d in_valid %b got %b want %b", s_pre, iv, shift_en, exp_sh);
                end
            end
        end
        tests_run++; if (flush_dry == 0) begin fail_cnt++; $display("FAIL starve_flush_advance got %0d want >0", flush_dry); end
        tests_run++; if (acc_cnt != NRES) begin fail_cnt++; $display("FAIL starve_accepts got %0d want %0d", acc_cnt, NRES); end
        tests_run++; if (got_q.size() != NRES) begin fail_cnt++; $display("FAIL starve_result_count got %0d want %0d", got_q.size(), NRES); end
        for (int k = 0; k < got_q.size() && k < NRES; k++) begin
            tests_run++; if (got_q[k] !== exp_result(k)) begin fail_cnt++; $display("FAIL starve_result[%0d] got %h want %h", k, got_q[k], exp_result(k)); end
        end
        tests_run++; if (done_cnt != 1) begin fail_cnt++; $display("FAIL starve_done got %0d want 1", done_cnt); end
    endtask

    task automatic test_backpressure();
        clear_counts();
        tick(1'b1, 1'b1, 1'b0);
        repeat (60) tick(1'b0, 1'b1, 1'b0);
        // Four productive positions (indices 18..21) fill all credits.
        tests_run++; if (shift_cnt != 2 * SW + 6) begin fail_cnt++; $display("FAIL bp_stall_pos got %0d want %0d", shift_cnt, 2 * SW + 6); end
        tests_run++; if (prod_cnt != 4) begin fail_cnt++; $display("FAIL bp_held got %0d want 4", prod_cnt); end
        tests_run++; if (shift_en !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b1) begin
            fail_cnt++; $display("FAIL bp_flags got shift=%b ov=%b busy=%b want 0,1,1", shift_en, out_valid, busy);
        end
        for (int n = 0; n < 600 && done_cnt == 0; n++) begin
            tick(1'b0, 1'b1, 1'($urandom_range(0, 1)));
            tests_run++;
            if (prod_cnt - got_q.size() > 4) begin fail_cnt++; $display("FAIL bp_occupancy got %0d want <=4", prod_cnt - got_q.size()); end
        end
        tests_run++; if (got_q.size() != NRES) begin fail_cnt++; $display("FAIL bp_result_count got %0d want %0d", got_q.size(), NRES); end
        for (int k = 0; k < got_q.size() && k < NRES; k++) begin
            tests_run++; if (got_q[k] !== exp_result(k)) begin fail_cnt++; $display("FAIL bp_result[%0d] got %h want %h", k, got_q[k], exp_result(k)); end
        end
        tests_run++; if (done_cnt != 1) begin fail_cnt++; $display("FAIL bp_done got %0d want 1", done_cnt); end
    endtask

    task automatic test_random();
        clear_counts();
        tick(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        for (int n = 0; n < 1000 && done_cnt == 0; n++) begin
            tick(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
            tests_run++;
            if (prod_cnt - got_q.size() > 4) begin fail_cnt++; $display("FAIL rand_occupancy got %0d want <=4", prod_cnt - got_q.size()); end
        end
        tests_run++; if (shift_cnt != NPOS || acc_cnt != NRES) begin
            fail_cnt++; $display("FAIL rand_counts got shifts=%0d acc=%0d want %0d,%0d", shift_cnt, acc_cnt, NPOS, NRES);
        end
        tests_run++; if (got_q.size() != NRES) begin fail_cnt++; $display("FAIL rand_result_count got %0d want %0d", got_q.size(), NRES); end
        for (int k = 0; k < got_q.size() && k < NRES; k++) begin
            tests_run++; if (got_q[k] !== exp_result(k)) begin fail_cnt++; $display("FAIL rand_result[%0d] got %h want %h", k, got_q[k], exp_result(k)); end
        end
        tests_run++; if (done_cnt != 1) begin fail_cnt++; $display("FAIL rand_done got %0d want 1", done_cnt); end
    endtask

    task automatic test_start_during_run();
        clear_counts();
        tick(1'b1, 1'b1, 1'b1);
        for (int n = 0; n < 200 && done_cnt == 0; n++) tick(1'(n % 5 == 2), 1'b1, 1'b1);
        repeat (4) tick(1'b0, 1'b1, 1'b1);
        tests_run++; if (shift_cnt != NPOS) begin fail_cnt++; $display("FAIL restart_shift_count got %0d want %0d", shift_cnt, NPOS); end
        tests_run++; if (got_q.size() != NRES) begin fail_cnt++; $display("FAIL restart_result_count got %0d want %0d", got_q.size(), NRES); end
        for (int k = 0; k < got_q.size() && k < NRES; k++) begin
            tests_run++; if (got_q[k] !== exp_result(k)) begin fail_cnt++; $display("FAIL restart_result[%0d] got %h want %h", k, got_q[k], exp_result(k)); end
        end
        tests_run++; if (done_cnt != 1 || busy !== 1'b0) begin fail_cnt++; $display("FAIL restart_done got done=%0d busy=%b want 1,0", done_cnt, busy); end
    endtask

    task automatic test_reset_mid_frame();
        clear_counts();
        tick(1'b1, 1'b1, 1'b1);
        for (int n = 0; n < 100 && shift_cnt < 20; n++) tick(1'b0, 1'b1, 1'b1);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        tests_run++; if (in_ready !== 1'b0 || shift_en !== 1'b0 || out_valid !== 1'b0) begin
            fail_cnt++; $display("FAIL midrst_handshake got ir=%b sh=%b ov=%b want 0,0,0", in_ready, shift_en, out_valid);
        end
        tests_run++; if (busy !== 1'b0 || frame_done !== 1'b0) begin fail_cnt++; $display("FAIL midrst_status got busy=%b fd=%b want 0,0", busy, frame_done); end
        tests_run++; if (x !== 4'd0 || y !== 3'd0) begin fail_cnt++; $display("FAIL midrst_xy got %0d,%0d want 0,0", x, y); end
        @(posedge clock);
        #1 reset = 1'b1;
        repeat (5) tick(1'b0, 1'b1, 1'b1);
        tests_run++; if (done_cnt != 0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            fail_cnt++; $display("FAIL midrst_quiet got done=%0d busy=%b ov=%b want 0,0,0", done_cnt, busy, out_valid);
        end
        clear_counts();
        tick(1'b1, 1'b1, 1'b1);
        for (int n = 0; n < 200 && done_cnt == 0; n++) tick(1'b0, 1'b1, 1'b1);
        tests_run++; if (shift_cnt != NPOS || acc_cnt != NRES) begin
            fail_cnt++; $display("FAIL midrst_rerun_counts got shifts=%0d acc=%0d want %0d,%0d", shift_cnt, acc_cnt, NPOS, NRES);
        end
        tests_run++; if (got_q.size() != NRES) begin fail_cnt++; $display("FAIL midrst_result_count got %0d want %0d", got_q.size(), NRES); end
        for (int k = 0; k < got_q.size() && k < NRES; k++) begin
            tests_run++; if (got_q[k] !== exp_result(k)) begin fail_cnt++; $display("FAIL midrst_result[%0d] got %h want %h", k, got_q[k], exp_result(k)); end
        end
        tests_run++; if (done_cnt != 1) begin fail_cnt++; $display("FAIL midrst_done got %0d want 1", done_cnt); end
    endtask

    initial begin
        clear_counts();
        test_reset();
        test_free_run();
        test_wrap();
        test_starvation();
        test_backpressure();
        test_random();
        test_start_during_run();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
